// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, taken-branch squash,
// data-memory freeze, post-reset start-up window and saturating event counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned STARTUP_CYC = 3,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             initPC,
  input  logic [4:0]       rs_1,
  input  logic [4:0]       rt_1,
  input  logic             uses_rt_1,
  input  logic             MemRead_2,
  input  logic [4:0]       rt_2,
  input  logic             Branch_3,
  input  logic             zero_3,
  input  logic             dmem_req_3,
  input  logic             dmem_ready,
  output logic             PCwrite,
  output logic             IFIDwrite,
  output logic             PCsrc,
  output logic             bubble_2,
  output logic             flush_1,
  output logic             flush_3,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {START, RUN, MEMWAIT} state_t;

  localparam logic [3:0] START_LOAD = 4'(STARTUP_CYC - 1);

  state_t     state;
  logic [3:0] start_cnt;

  logic mem_wait, taken, load_use;
  logic waiting, evaluate, do_flush, do_lu;

  assign mem_wait = dmem_req_3 & ~dmem_ready;
  assign taken    = Branch_3 & zero_3;
  assign load_use = MemRead_2 & (rt_2 != '0) &
                    ((rt_2 == rs_1) | (uses_rt_1 & (rt_2 == rt_1)));

  // In MEMWAIT the release cycle is a normal RUN evaluation with mem_wait masked.
  assign waiting  = ((state == RUN) & mem_wait) | ((state == MEMWAIT) & ~dmem_ready);
  assign evaluate = ((state == RUN) & ~mem_wait) | ((state == MEMWAIT) & dmem_ready);
  assign do_flush = evaluate & taken;
  assign do_lu    = evaluate & ~taken & load_use;

  always_comb begin
    PCwrite   = 1'b0;
    IFIDwrite = 1'b0;
    PCsrc     = 1'b0;
    bubble_2  = 1'b0;
    flush_1   = 1'b0;
    flush_3   = 1'b0;
    freeze    = 1'b0;
    if (state == START) begin
      bubble_2 = 1'b1;
      flush_1  = 1'b1;
      flush_3  = 1'b1;
    end else if (waiting) begin
      freeze = 1'b1;
    end else if (do_flush) begin
      PCsrc     = 1'b1;
      PCwrite   = 1'b1;
      IFIDwrite = 1'b1;
      flush_1   = 1'b1;
      bubble_2  = 1'b1;
      flush_3   = 1'b1;
    end else if (do_lu) begin
      bubble_2 = 1'b1;
    end else begin
      PCwrite   = 1'b1;
      IFIDwrite = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge initPC) begin
    if (!initPC) begin
      state     <= START;
      start_cnt <= START_LOAD;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        START: begin
          if (start_cnt == '0) state <= RUN;
          else start_cnt <= start_cnt - 1'b1;
        end
        RUN:     if (mem_wait) state <= MEMWAIT;
        MEMWAIT: if (dmem_ready) state <= RUN;
        default: state <= START;
      endcase
      if ((waiting | do_lu) && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (do_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: expected control vectors and counter increments
// are queued as each step is driven and popped when the outputs are sampled.
module tb_pipeline_hazard_ctrl;

  localparam logic [6:0] START_V = 7'b0001110;
  localparam logic [6:0] WAIT_V  = 7'b0000001;
  localparam logic [6:0] TAKEN_V = 7'b1111110;
  localparam logic [6:0] LU_V    = 7'b0001000;
  localparam logic [6:0] NORM_V  = 7'b1100000;

  logic        clk = 1'b0;
  logic        initPC;
  logic [4:0]  rs_1, rt_1, rt_2;
  logic        uses_rt_1, MemRead_2, Branch_3, zero_3, dmem_req_3, dmem_ready;
  logic        PCwrite, IFIDwrite, PCsrc, bubble_2, flush_1, flush_3, freeze;
  logic [15:0] stall_cnt, flush_cnt;
  logic        s_PCwrite, s_IFIDwrite, s_PCsrc, s_bubble_2, s_flush_1, s_flush_3, s_freeze;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  pipeline_hazard_ctrl dut (
    .clk(clk), .initPC(initPC), .rs_1(rs_1), .rt_1(rt_1), .uses_rt_1(uses_rt_1),
    .MemRead_2(MemRead_2), .rt_2(rt_2), .Branch_3(Branch_3), .zero_3(zero_3),
    .dmem_req_3(dmem_req_3), .dmem_ready(dmem_ready), .PCwrite(PCwrite),
    .IFIDwrite(IFIDwrite), .PCsrc(PCsrc), .bubble_2(bubble_2), .flush_1(flush_1),
    .flush_3(flush_3), .freeze(freeze), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_ctrl #(.STARTUP_CYC(1), .CNT_W(2)) dut_small (
    .clk(clk), .initPC(initPC), .rs_1(rs_1), .rt_1(rt_1), .uses_rt_1(uses_rt_1),
    .MemRead_2(MemRead_2), .rt_2(rt_2), .Branch_3(Branch_3), .zero_3(zero_3),
    .dmem_req_3(dmem_req_3), .dmem_ready(dmem_ready), .PCwrite(s_PCwrite),
    .IFIDwrite(s_IFIDwrite), .PCsrc(s_PCsrc), .bubble_2(s_bubble_2), .flush_1(s_flush_1),
    .flush_3(s_flush_3), .freeze(s_freeze), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] ctl;
    logic       stall_inc;
    logic       flush_inc;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [15:0] exp_stall = '0;
  logic [15:0] exp_flush = '0;
  logic [6:0]  ctl, s_ctl;

  assign ctl   = {PCwrite, IFIDwrite, PCsrc, bubble_2, flush_1, flush_3, freeze};
  assign s_ctl = {s_PCwrite, s_IFIDwrite, s_PCsrc, s_bubble_2, s_flush_1, s_flush_3, s_freeze};

  task automatic check_now(input string tag, input logic [6:0] ctl_e,
                           input logic si, input logic fi);
    exp_t e;
    sb.push_back('{ctl: ctl_e, stall_inc: si, flush_inc: fi});
    e = sb.pop_front();
    n_assert++;
    assert (ctl === e.ctl) else begin
      n_fail++;
      $error("FAIL %s ctl observed=%b expected=%b", tag, ctl, e.ctl);
    end
    n_assert++;
    assert (stall_cnt === exp_stall) else begin
      n_fail++;
      $error("FAIL %s stall_cnt observed=%0d expected=%0d", tag, stall_cnt, exp_stall);
    end
    n_assert++;
    assert (flush_cnt === exp_flush) else begin
      n_fail++;
      $error("FAIL %s flush_cnt observed=%0d expected=%0d", tag, flush_cnt, exp_flush);
    end
    exp_stall = exp_stall + 16'(e.stall_inc);
    exp_flush = exp_flush + 16'(e.flush_inc);
  endtask

  task automatic step(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urt, input logic mr, input logic [4:0] rt2,
                      input logic br, input logic z, input logic req, input logic rdy,
                      input logic [6:0] ctl_e, input logic si, input logic fi);
    @(negedge clk);
    rs_1 = rs; rt_1 = rt; uses_rt_1 = urt; MemRead_2 = mr; rt_2 = rt2;
    Branch_3 = br; zero_3 = z; dmem_req_3 = req; dmem_ready = rdy;
    #1 check_now(tag, ctl_e, si, fi);
  endtask

  task automatic check_small(input string tag, input logic [6:0] ctl_e,
                             input logic [1:0] st_e, input logic [1:0] fl_e);
    n_assert++;
    assert (s_ctl === ctl_e) else begin
      n_fail++;
      $error("FAIL %s small ctl observed=%b expected=%b", tag, s_ctl, ctl_e);
    end
    n_assert++;
    assert (s_stall_cnt === st_e) else begin
      n_fail++;
      $error("FAIL %s small stall_cnt observed=%0d expected=%0d", tag, s_stall_cnt, st_e);
    end
    n_assert++;
    assert (s_flush_cnt === fl_e) else begin
      n_fail++;
      $error("FAIL %s small flush_cnt observed=%0d expected=%0d", tag, s_flush_cnt, fl_e);
    end
  endtask

  initial begin
    initPC = 1'b0;
    rs_1 = '0; rt_1 = '0; uses_rt_1 = 1'b0; MemRead_2 = 1'b0; rt_2 = '0;
    Branch_3 = 1'b0; zero_3 = 1'b0; dmem_req_3 = 1'b0; dmem_ready = 1'b1;
    repeat (2) @(negedge clk);

    // T1: reset and start-up window
    step("rst_hold", 0, 0, 0, 0, 0, 0, 0, 0, 1, START_V, 0, 0);
    initPC = 1'b1;
    #1 check_now("start0", START_V, 0, 0);
    step("start1", 0, 0, 0, 0, 0, 0, 0, 0, 1, START_V, 0, 0);
    step("start2", 0, 0, 0, 0, 0, 0, 0, 0, 1, START_V, 0, 0);
    step("run0",   0, 0, 0, 0, 0, 0, 0, 0, 1, NORM_V,  0, 0);

    // T2: load-use hazards
    step("lu_rs",      2, 4, 1, 1, 2, 0, 0, 0, 1, LU_V,   1, 0);
    step("lu_after",   3, 4, 1, 0, 0, 0, 0, 0, 1, NORM_V, 0, 0);
    step("lu_zero",    0, 4, 1, 1, 0, 0, 0, 0, 1, NORM_V, 0, 0);
    step("lu_rt_nouse",5, 2, 0, 1, 2, 0, 0, 0, 1, NORM_V, 0, 0);
    step("lu_rt_use",  5, 2, 1, 1, 2, 0, 0, 0, 1, LU_V,   1, 0);
    step("lu_idle",    0, 0, 0, 0, 0, 0, 0, 0, 1, NORM_V, 0, 0);

    // T3: branches
    step("br_taken",   0, 0, 0, 0, 0, 1, 1, 0, 1, TAKEN_V, 0, 1);
    step("br_not",     0, 0, 0, 0, 0, 1, 0, 0, 1, NORM_V,  0, 0);

    // T5: taken branch beats load-use
    step("br_over_lu", 2, 0, 0, 1, 2, 1, 1, 0, 1, TAKEN_V, 0, 1);
    step("br_lu_idle", 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM_V,  0, 0);

    // T4: data-memory wait of four cycles
    for (int i = 0; i < 4; i++)
      step("mem_wait", 0, 0, 0, 0, 0, 0, 0, 1, 0, WAIT_V, 1, 0);
    step("mem_rel",    0, 0, 0, 0, 0, 0, 0, 1, 1, NORM_V, 0, 0);
    step("mem_idle",   0, 0, 0, 0, 0, 0, 0, 0, 1, NORM_V, 0, 0);

    // Branch deferred by a wait and honoured on release; likewise a load-use
    step("def_br_wait",0, 0, 0, 0, 0, 1, 1, 1, 0, WAIT_V,  1, 0);
    step("def_br_rel", 0, 0, 0, 0, 0, 1, 1, 1, 1, TAKEN_V, 0, 1);
    step("def_lu_wait",7, 0, 0, 1, 7, 0, 0, 1, 0, WAIT_V,  1, 0);
    step("def_lu_rel", 7, 0, 0, 1, 7, 0, 0, 1, 1, LU_V,    1, 0);
    step("def_idle",   0, 0, 0, 0, 0, 0, 0, 0, 1, NORM_V,  0, 0);

    // T6: asynchronous reset while in MEMWAIT
    step("t6_wait0",   0, 0, 0, 0, 0, 1, 1, 1, 0, WAIT_V, 1, 0);
    step("t6_wait1",   0, 0, 0, 0, 0, 1, 1, 1, 0, WAIT_V, 1, 0);
    #2 initPC = 1'b0;
    exp_stall = '0;
    exp_flush = '0;
    #1 check_now("t6_async", START_V, 0, 0);
    step("t6_hold",    0, 0, 0, 0, 0, 1, 1, 1, 0, START_V, 0, 0);
    initPC = 1'b1;
    #1 check_now("t6_start0", START_V, 0, 0);
    step("t6_start1",  0, 0, 0, 0, 0, 1, 1, 1, 0, START_V, 0, 0);
    step("t6_start2",  0, 0, 0, 0, 0, 0, 0, 0, 1, START_V, 0, 0);
    step("t6_run",     0, 0, 0, 0, 0, 0, 0, 0, 1, NORM_V,  0, 0);

    // Saturation and one-cycle start-up on the narrow instance
    @(negedge clk);
    initPC = 1'b0;
    #1;
    @(negedge clk);
    rs_1 = 5'd9; rt_1 = 5'd0; uses_rt_1 = 1'b0; MemRead_2 = 1'b1; rt_2 = 5'd9;
    Branch_3 = 1'b0; zero_3 = 1'b0; dmem_req_3 = 1'b0; dmem_ready = 1'b1;
    initPC = 1'b1;
    #1 check_small("sat_start", START_V, 2'd0, 2'd0);
    for (int k = 2; k <= 7; k++) begin
      @(negedge clk);
      #1 check_small("sat_stall", LU_V, (k - 2 > 3) ? 2'd3 : 2'(k - 2), 2'd0);
    end
    for (int j = 0; j <= 5; j++) begin
      @(negedge clk);
      Branch_3 = 1'b1; zero_3 = 1'b1;
      #1 check_small("sat_flush", TAKEN_V, 2'd3, (j > 3) ? 2'd3 : 2'(j));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
